fir_output_requantizer: RTL and testbench
=========================================

# fir_output_requantizer

Downstream stage of the pipelined low-pass `filter`. It takes the full-precision signed 64-bit `y_out` stream and rounds away the coefficient fractional bits. It saturates the result to a signed 32-bit sample, decimates by a fixed factor, and buffers samples in a small FIFO behind a ready/valid output. Saturation and overflow events are counted so that spectral tests on the 2 GHz path can flag clipped or dropped samples.

## Interface
- `IN_W`, 64, input sample width; matches filter `y_out`.
- `OUT_W`, 32, output sample width; matches filter `x_in` format.
- `SHIFT`, 31, number of fractional bits removed (coefficient Q format); 1 ≤ SHIFT < IN_W.
- `DECIM`, 4, decimation factor; 1 = pass every sample.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `y_in`  in  IN_W  signed filter output.
- `in_valid`  in  1  `y_in` is a valid sample this cycle. No backpressure upstream.
- `out_data`  out  OUT_W  signed requantized sample at FIFO head.
- `out_sat`  out  1  head sample was saturated.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `sat_cnt`  out  16  saturating count of kept samples that saturated.
- `overflow_cnt`  out  16  saturating count of kept samples dropped on a full FIFO.
- `overflow`  out  1  sticky; set on the first drop, cleared only by reset.

## Operation
- **Stage 1 (round)**, on `in_valid`:
  - Sign-extend `y_in` to IN_W+1 bits.
  - Add 2^(SHIFT-1).
  - Arithmetic right-shift by SHIFT. Rounding is round-half-up (toward +inf on ties).
  - Register the result with a valid bit.
- **Stage 2 (saturate + decimate)**:
  - Result > 2^(OUT_W-1)−1 → 0x7FFF_FFFF, sat=1.
  - Result < −2^(OUT_W-1) → 0x8000_0000, sat=1.
  - Otherwise truncate to OUT_W bits, sat=0.
  - Phase counter runs 0..DECIM−1 and advances only on stage-1 valid, wrapping to 0.
  - A sample is kept when phase==0; the first valid sample after reset is kept.
  - Kept sample plus its sat flag are registered as a push request.
- **FIFO**:
  - Push a kept sample unless the FIFO is full.
  - Pop when `out_valid && out_ready`.
  - Full with simultaneous push and pop: both occur, no drop.
  - Full with push and no pop: sample dropped, `overflow_cnt` increments, `overflow` sets.
  - Empty with push: the sample becomes the head next cycle; no bypass.
- **Counters**:
  - `sat_cnt` increments for each kept saturated sample, including dropped ones.
  - Both counters stick at 0xFFFF.
- **Reset** (async, any time): FIFO empties, pipeline valids clear, phase returns to 0, counters and `overflow` clear. Any in-flight samples are lost.

## Timing
- Reset values: `out_data`=0, `out_sat`=0, `out_valid`=0, `sat_cnt`=0, `overflow_cnt`=0, `overflow`=0.
- Latency:
  - Sample with `in_valid` in cycle 0 → stage 1 at edge 1 → stage 2 at edge 2 → FIFO write at edge 3.
  - With an empty FIFO, `out_valid`=1 and `out_data` are visible in cycle 3.
- Throughput: one input per cycle sustained; one output per DECIM valid inputs.
- `out_data`/`out_sat` hold stable while `out_valid && !out_ready`.
- `in_valid` gaps stall the phase counter; they do not insert zero samples.
- Counters update on the edge of the drop/saturation event and are visible the next cycle.

## Test plan
- **Rounding** (DECIM=1): `y_in` = 3·2^30, 2^30−1, −2^30, −3·2^30 → `out_data` = 2, 0, 0, −1 in order; `out_sat`=0; first output in cycle 3.
- **Saturation**: `y_in` = 2^62, then −2^63 → `out_data` = 0x7FFF_FFFF, then 0x8000_0000; `out_sat`=1 both; `sat_cnt`=2.
- **Decimation** (DECIM=4): continuous `in_valid`, `y_in` = k·2^31 for k=0..11, `out_ready`=1 → outputs 0, 4, 8 only. With `in_valid` toggling every other cycle → same three outputs.
- **Backpressure** (DECIM=1, depth 4): `out_ready`=0, feed 1..6 (·2^31) → `out_valid`=1, `overflow_cnt`=2, `overflow`=1. Then `out_ready`=1 drains 1, 2, 3, 4 and `out_valid` drops; push and pop together at full loses nothing.
- **Reset mid-stream**: assert `rst` with 3 entries queued and 2 in the pipeline → all outputs return to reset values immediately. After release, feed 5·2^31 → outputs exactly 5 in cycle 3 with phase restarted (kept).

Source files
------------

// File: rtl/fir_output_requantizer.sv
// Requantizer behind the pipelined low-pass filter.
// Rounds the 64-bit accumulator output half-up, drops SHIFT fractional bits,
// saturates to OUT_W, keeps one sample in DECIM and queues it in a small FIFO
// behind a ready/valid port. Clipped and dropped samples are counted.
module fir_output_requantizer #(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 32,
    parameter int SHIFT      = 31,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  y_in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      sat_cnt,
    output logic [15:0]      overflow_cnt,
    output logic             overflow
);

    localparam int STAGES = 2;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    // Rounding constant 2^(SHIFT-1) at the extended width.
    localparam logic [IN_W:0] ONE_EXT = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] RND = ONE_EXT << (SHIFT - 1);
    // Representable OUT_W range, expressed at the extended width.
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } smp_t;

    // ---------------- stage 1: round ----------------
    // One guard bit above IN_W keeps the +2^(SHIFT-1) from wrapping.
    logic signed [IN_W:0] y_ext, y_sum, y_rnd;
    logic signed [IN_W:0] s1_val;
    logic [STAGES:1]      vld_pipe;

    assign y_ext = $signed({y_in[IN_W-1], y_in});
    assign y_sum = y_ext + RND;
    assign y_rnd = y_sum >>> SHIFT;

    // Capture the rounded value of each valid input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           s1_val <= '0;
        else if (in_valid) s1_val <= y_rnd;
    end

    // ---------------- stage 2: saturate + decimate ----------------
    logic             hi, lo, keep;
    logic [PH_W-1:0]  phase;
    smp_t             sat_smp, s2_smp;

    assign hi   = (s1_val > MAX_V);
    assign lo   = (s1_val < MIN_V);
    assign keep = (phase == '0);

    // Clamp to the OUT_W range and flag any clipping.
    always_comb begin
        sat_smp.sat  = hi | lo;
        sat_smp.data = s1_val[OUT_W-1:0];
        if (hi)      sat_smp.data = {1'b0, {(OUT_W-1){1'b1}}};
        else if (lo) sat_smp.data = {1'b1, {(OUT_W-1){1'b0}}};
    end

    // Phase only moves on real samples, so input gaps never shift the pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              phase <= '0;
        else if (vld_pipe[1]) phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
    end

    // Register the kept sample as the FIFO push request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      s2_smp <= '0;
        else if (vld_pipe[1] && keep) s2_smp <= sat_smp;
    end

    // Pipeline valid shift register; stage 2 valid means "kept".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else begin
            vld_pipe[1] <= in_valid;
            vld_pipe[2] <= vld_pipe[1] && keep;
        end
    end

    // ---------------- output FIFO ----------------
    smp_t          mem [FIFO_DEPTH];
    smp_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, drop;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = vld_pipe[STAGES] && (!full || pop);
    assign drop  = vld_pipe[STAGES] && full && !pop;

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s2_smp;
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head.data;
    assign out_sat   = empty ? 1'b0 : head.sat;

    // ---------------- event counters ----------------
    // Saturation is counted when the sample is kept, whether or not it is later dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (vld_pipe[1] && keep && sat_smp.sat && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end

    // Count drops on a full FIFO and latch the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_cnt <= '0;
            overflow     <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Bench for fir_output_requantizer: one instance with DECIM=1, one with DECIM=4.
// Expected samples are queued when driven and checked when the DUT hands them out.
module tb_fir_output_requantizer;

    typedef struct {
        logic [63:0] y;
        logic [31:0] d;
        logic        s;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] y1, y2;
    logic        v1, v2, r1, r2;
    logic [31:0] od1, od2;
    logic        os1, os2, oval1, oval2, of1, of2;
    logic [15:0] sc1, sc2, oc1, oc2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t tbl[12];
    int   n_run  = 0;
    int   n_fail = 0;
    int   nsat;

    always #5 clk = ~clk;

    fir_output_requantizer #(.IN_W(64), .OUT_W(32), .SHIFT(31), .DECIM(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .y_in(y1), .in_valid(v1),
        .out_data(od1), .out_sat(os1), .out_valid(oval1), .out_ready(r1),
        .sat_cnt(sc1), .overflow_cnt(oc1), .overflow(of1)
    );

    fir_output_requantizer #(.IN_W(64), .OUT_W(32), .SHIFT(31), .DECIM(4), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .y_in(y2), .in_valid(v2),
        .out_data(od2), .out_sat(os2), .out_valid(oval2), .out_ready(r2),
        .sat_cnt(sc2), .overflow_cnt(oc2), .overflow(of2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send1(input logic [63:0] y, input logic [31:0] d, input logic s, input bit push);
        @(posedge clk); #1;
        y1 = y; v1 = 1'b1;
        if (push) q1.push_back('{d, s});
    endtask

    task automatic send2(input logic [63:0] y, input logic [31:0] d, input bit push);
        @(posedge clk); #1;
        y2 = y; v2 = 1'b1;
        if (push) q2.push_back('{d, 1'b0});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
    endtask

    // Scoreboard for the DECIM=1 instance.
    always @(negedge clk) begin
        if (!rst && oval1 && r1) begin
            if (q1.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL dut1 unexpected output: got %h expected none", od1);
            end else begin
                e1 = q1.pop_front();
                check("dut1 data", 64'(od1), 64'(e1.d));
                check("dut1 sat", 64'(os1), 64'(e1.s));
            end
        end
    end

    // Scoreboard for the DECIM=4 instance.
    always @(negedge clk) begin
        if (!rst && oval2 && r2) begin
            if (q2.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL dut2 unexpected output: got %h expected none", od2);
            end else begin
                e2 = q2.pop_front();
                check("dut2 data", 64'(od2), 64'(e2.d));
                check("dut2 sat", 64'(os2), 64'(e2.s));
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{64'h0000_0000_C000_0000, 32'h0000_0002, 1'b0};
        tbl[1]  = '{64'h0000_0000_3FFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[2]  = '{64'hFFFF_FFFF_C000_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{64'hFFFF_FFFF_4000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{64'h4000_0000_0000_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[5]  = '{64'h8000_0000_0000_0000, 32'h8000_0000, 1'b1};
        tbl[6]  = '{64'h3FFF_FFFF_BFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        tbl[7]  = '{64'h3FFF_FFFF_C000_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[8]  = '{64'hC000_0000_0000_0000, 32'h8000_0000, 1'b0};
        tbl[9]  = '{64'hBFFF_FFFF_BFFF_FFFF, 32'h8000_0000, 1'b1};
        tbl[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        tbl[11] = '{64'h0000_0000_4000_0000, 32'h0000_0001, 1'b0};

        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; r1 = 1'b1; r2 = 1'b1; y1 = '0; y2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_data", 64'(od1), 64'd0);
        check("reset out_sat", 64'(os1), 64'd0);
        check("reset out_valid", 64'(oval1), 64'd0);
        check("reset sat_cnt", 64'(sc1), 64'd0);
        check("reset overflow_cnt", 64'(oc1), 64'd0);
        check("reset overflow", 64'(of1), 64'd0);
        check("reset dut2 out_valid", 64'(oval2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First-output latency: sample in cycle 0, visible in cycle 3.
        send1(64'h0000_0000_C000_0000, 32'd2, 1'b0, 1'b1);
        idle(1);
        @(negedge clk); check("latency c1 out_valid", 64'(oval1), 64'd0);
        @(negedge clk); check("latency c2 out_valid", 64'(oval1), 64'd0);
        @(negedge clk); check("latency c3 out_valid", 64'(oval1), 64'd1);
        idle(4);

        // Rounding + saturation vectors, back to back.
        for (int i = 0; i < 6; i++) send1(tbl[i].y, tbl[i].d, tbl[i].s, 1'b1);
        idle(1);
        idle(6);
        check("sat_cnt after saturation pair", 64'(sc1), 64'd2);
        for (int i = 6; i < 12; i++) send1(tbl[i].y, tbl[i].d, tbl[i].s, 1'b1);
        idle(1);
        idle(6);
        nsat = 0;
        for (int i = 0; i < 12; i++) nsat += int'(tbl[i].s);
        check("sat_cnt after table", 64'(sc1), 64'(nsat));
        check("table drained", 64'(q1.size()), 64'd0);

        // Decimation by 4, continuous input.
        for (int k = 0; k < 12; k++) send2(64'(k) << 31, 32'(k), (k % 4) == 0);
        idle(1);
        idle(6);
        check("decim continuous drained", 64'(q2.size()), 64'd0);
        // Decimation with in_valid toggling.
        for (int k = 0; k < 12; k++) begin
            send2(64'(k) << 31, 32'(k), (k % 4) == 0);
            idle(1);
        end
        idle(6);
        check("decim toggled drained", 64'(q2.size()), 64'd0);
        check("decim sat_cnt", 64'(sc2), 64'd0);

        // Backpressure: 6 samples into a 4-deep FIFO, last two dropped.
        @(posedge clk); #1; r1 = 1'b0;
        for (int k = 1; k <= 6; k++) send1(64'(k) << 31, 32'(k), 1'b0, k <= 4);
        idle(1);
        idle(6);
        check("bp out_valid", 64'(oval1), 64'd1);
        check("bp overflow_cnt", 64'(oc1), 64'd2);
        check("bp overflow", 64'(of1), 64'd1);
        check("bp head", 64'(od1), 64'd1);
        idle(3);
        check("bp head hold", 64'(od1), 64'd1);
        r1 = 1'b1;
        idle(8);
        check("bp drained out_valid", 64'(oval1), 64'd0);
        check("bp drained queue", 64'(q1.size()), 64'd0);

        // Push arriving on a full FIFO in the same cycle as a pop.
        r1 = 1'b0;
        for (int k = 7; k <= 10; k++) send1(64'(k) << 31, 32'(k), 1'b0, 1'b1);
        idle(1);
        idle(5);
        send1(64'd11 << 31, 32'd11, 1'b0, 1'b1);
        idle(1);
        @(posedge clk); #1; r1 = 1'b1;
        idle(8);
        check("full push+pop overflow_cnt", 64'(oc1), 64'd2);
        check("full push+pop drained", 64'(q1.size()), 64'd0);

        // Move dut2 phase off zero before reset.
        send2(64'd100 << 31, 32'd100, 1'b1);
        send2(64'd101 << 31, 32'd101, 1'b0);
        idle(1);
        idle(6);
        check("dut2 pre-reset drained", 64'(q2.size()), 64'd0);

        // Reset with 3 queued and 2 in the pipeline.
        r1 = 1'b0;
        for (int k = 20; k <= 24; k++) send1(64'(k) << 31, 32'(k), 1'b0, 1'b1);
        idle(1);
        check("pre-reset out_valid", 64'(oval1), 64'd1);
        rst = 1'b1;
        #1;
        check("midreset out_data", 64'(od1), 64'd0);
        check("midreset out_valid", 64'(oval1), 64'd0);
        check("midreset overflow_cnt", 64'(oc1), 64'd0);
        check("midreset overflow", 64'(of1), 64'd0);
        check("midreset sat_cnt", 64'(sc1), 64'd0);
        q1.delete();
        q2.delete();
        @(posedge clk); #1;
        rst = 1'b0; r1 = 1'b1;
        @(posedge clk); #1;
        y1 = 64'd5 << 31; v1 = 1'b1; q1.push_back('{32'd5, 1'b0});
        y2 = 64'd5 << 31; v2 = 1'b1; q2.push_back('{32'd5, 1'b0});
        idle(1);
        @(negedge clk);
        @(negedge clk); check("post-reset c2 out_valid", 64'(oval1), 64'd0);
        @(negedge clk);
        check("post-reset c3 out_valid", 64'(oval1), 64'd1);
        check("post-reset c3 out_data", 64'(od1), 64'd5);
        check("post-reset phase restart", 64'(oval2), 64'd1);
        check("post-reset dut2 out_data", 64'(od2), 64'd5);
        idle(5);
        check("post-reset dut1 drained", 64'(q1.size()), 64'd0);
        check("post-reset dut2 drained", 64'(q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
